// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared encodings for the RV32I execute-stage ALU: opcode values, ALU
//   funct3 selects and branch funct3 selects, plus a sign-extension helper.
//   Imported by alu and alu_branch_cmp.
package alu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if
//   Decoder-to-ALU bundle: decoded instruction fields and operands toward
//   the ALU, registered result and branch flag back.
//   master : decoder / issue side (drives fields, reads results)
//   slave  : alu (reads fields, drives ALU_result and branch)
interface alu_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [11:0] imm_b;
  logic [20:0] imm_j;
  logic [19:0] imm_u;
  logic [31:0] imm32;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [15:0] pc;
  logic [31:0] ALU_result;
  logic        branch;

  modport master (
    output opcode, funct3, funct7, rs1, rs2, rd, imm_i, imm_s, imm_b, imm_j,
           imm_u, imm32, read_data1, read_data2, pc,
    input  ALU_result, branch
  );

  modport slave (
    input  opcode, funct3, funct7, rs1, rs2, rd, imm_i, imm_s, imm_b, imm_j,
           imm_u, imm32, read_data1, read_data2, pc,
    output ALU_result, branch
  );
endinterface

// File: rtl/alu_branch_cmp.sv
// alu_branch_cmp
//   Combinational branch condition evaluation.
//   rs1_val_i, rs2_val_i : operands (32)
//   funct3_i             : branch type (3); 010/011 are not branches
//   taken_o              : condition holds
module alu_branch_cmp
  import alu_pkg::*;
(
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  input  logic [2:0]  funct3_i,
  output logic        taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_val_i == rs2_val_i);
      F3_BNE:  taken_o = (rs1_val_i != rs2_val_i);
      F3_BLT:  taken_o = ($signed(rs1_val_i) <  $signed(rs2_val_i));
      F3_BGE:  taken_o = ($signed(rs1_val_i) >= $signed(rs2_val_i));
      F3_BLTU: taken_o = (rs1_val_i <  rs2_val_i);
      F3_BGEU: taken_o = (rs1_val_i >= rs2_val_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// alu
//   RV32I execute-stage ALU. Computes integer result, load/store address,
//   link address or upper immediate, and the branch/jump-taken flag; both are
//   registered with one cycle of latency.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset, clears ALU_result and branch
//   bus   : alu_if.slave (decoded fields in, ALU_result/branch out)
//   Build option: define ALU_LUI_AUIPC_EN to compute LUI/AUIPC; otherwise
//   those opcodes produce result 0, branch 0.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sxi;
  logic [31:0] pc32;
  logic [4:0]  shamt;
  logic        taken;
  logic [31:0] result_d, result_q;
  logic        branch_d, branch_q;

  assign a     = bus.read_data1;
  assign b     = bus.read_data2;
  assign sxi   = sext12(bus.imm_i);
  assign pc32  = {16'b0, bus.pc};
  // Decoder routes every shift amount (register or immediate) via imm32.
  assign shamt = bus.imm32[4:0];

  alu_branch_cmp u_cmp (
    .rs1_val_i (a),
    .rs2_val_i (b),
    .funct3_i  (bus.funct3),
    .taken_o   (taken)
  );

  always_comb begin
    result_d = '0;
    branch_d = 1'b0;
    case (bus.opcode)
      OP_R: begin
        case (bus.funct3)
          F3_ADD:  result_d = bus.funct7[5] ? (a - b) : (a + b);
          F3_SLL:  result_d = a << shamt;
          F3_SLT:  result_d = {31'b0, $signed(a) < $signed(b)};
          F3_SLTU: result_d = {31'b0, a < b};
          F3_XOR:  result_d = a ^ b;
          F3_SR:   result_d = bus.funct7[5] ? 32'($signed(a) >>> shamt) : (a >> shamt);
          F3_OR:   result_d = a | b;
          F3_AND:  result_d = a & b;
        endcase
      end
      OP_I: begin
        case (bus.funct3)
          F3_ADD:  result_d = a + sxi;
          F3_SLL:  result_d = a << shamt;
          F3_SLT:  result_d = {31'b0, $signed(a) < $signed(sxi)};
          F3_SLTU: result_d = {31'b0, a < sxi};
          F3_XOR:  result_d = a ^ sxi;
          F3_SR:   result_d = bus.funct7[5] ? 32'($signed(a) >>> shamt) : (a >> shamt);
          F3_OR:   result_d = a | sxi;
          F3_AND:  result_d = a & sxi;
        endcase
      end
      OP_LOAD, OP_STORE: result_d = a + bus.imm32;
      OP_BRANCH: begin
        branch_d = taken;
        result_d = {31'b0, taken};
      end
      OP_JAL, OP_JALR: begin
        result_d = pc32 + 32'd4;
        branch_d = 1'b1;
      end
`ifdef ALU_LUI_AUIPC_EN
      OP_LUI:   result_d = {bus.imm_u, 12'b0};
      OP_AUIPC: result_d = pc32 + {bus.imm_u, 12'b0};
`endif
      default: begin
        result_d = '0;
        branch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end

  assign bus.ALU_result = result_q;
  assign bus.branch     = branch_q;

  // Debug-only fields and immediates the decoder already folds into imm32.
  logic unused_fields;
  assign unused_fields = ^{bus.rs1, bus.rs2, bus.rd, bus.imm_s, bus.imm_b,
                           bus.imm_j, bus.funct7[6], bus.funct7[4:0]};
`ifndef ALU_LUI_AUIPC_EN
  logic unused_imm_u;
  assign unused_imm_u = ^bus.imm_u;
`endif

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  alu_if bus_if ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: ISA semantics expressed with plain integer arithmetic.
  function automatic void model(
    input  logic [6:0]  op, input logic [2:0] f3, input logic [6:0] f7,
    input  logic [11:0] ii, input logic [19:0] iu, input logic [31:0] i32,
    input  logic [31:0] x,  input logic [31:0] y, input logic [15:0] p,
    output logic [31:0] res, output logic br);
    int          sh;
    int          simm;
    logic [31:0] uimm;
    logic [31:0] opb;
    longint      ux, uy;
    bit          t;
    res  = 32'd0;
    br   = 1'b0;
    sh   = int'(i32 % 32);
    simm = (ii >= 12'd2048) ? int'(ii) - 4096 : int'(ii);
    uimm = 32'(simm);
    case (op)
      7'b0110011, 7'b0010011: begin
        opb = (op == 7'b0110011) ? y : uimm;
        ux  = longint'(x);
        uy  = longint'(opb);
        case (f3)
          3'd0: res = (op == 7'b0110011 && f7[5]) ? 32'(ux - uy) : 32'(ux + uy);
          3'd1: res = 32'(ux * (64'd1 << sh));
          3'd2: res = (int'(x) < int'(opb)) ? 32'd1 : 32'd0;
          3'd3: res = (ux < uy) ? 32'd1 : 32'd0;
          3'd4: res = x ^ opb;
          3'd5: res = f7[5] ? 32'(int'(x) >>> sh) : 32'(ux / (64'd1 << sh));
          3'd6: res = x | opb;
          default: res = x & opb;
        endcase
      end
      7'b0000011, 7'b0100011: res = 32'(longint'(x) + longint'(i32));
      7'b1100011: begin
        case (f3)
          3'd0: t = (x == y);
          3'd1: t = (x != y);
          3'd4: t = int'(x) <  int'(y);
          3'd5: t = int'(x) >= int'(y);
          3'd6: t = longint'(x) <  longint'(y);
          3'd7: t = longint'(x) >= longint'(y);
          default: t = 1'b0;
        endcase
        br  = t;
        res = t ? 32'd1 : 32'd0;
      end
      7'b1101111, 7'b1100111: begin
        res = 32'(int'(p) + 4);
        br  = 1'b1;
      end
`ifdef ALU_LUI_AUIPC_EN
      7'b0110111: res = 32'(longint'(iu) * 4096);
      7'b0010111: res = 32'(longint'(iu) * 4096 + longint'(p));
`endif
      default: ;
    endcase
  endfunction

  task automatic apply(
    input logic [6:0]  op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [11:0] ii, input logic [19:0] iu, input logic [31:0] i32,
    input logic [31:0] x,  input logic [31:0] y, input logic [15:0] p);
    bus_if.opcode     = op;
    bus_if.funct3     = f3;
    bus_if.funct7     = f7;
    bus_if.imm_i      = ii;
    bus_if.imm_u      = iu;
    bus_if.imm32      = i32;
    bus_if.read_data1 = x;
    bus_if.read_data2 = y;
    bus_if.pc         = p;
    bus_if.rs1        = 5'($urandom);
    bus_if.rs2        = 5'($urandom);
    bus_if.rd         = 5'($urandom);
    bus_if.imm_s      = 12'($urandom);
    bus_if.imm_b      = 12'($urandom);
    bus_if.imm_j      = 21'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Directed case checked against hand-derived constants.
  task automatic dir(
    input string tag,
    input logic [6:0]  op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [11:0] ii, input logic [19:0] iu, input logic [31:0] i32,
    input logic [31:0] x,  input logic [31:0] y, input logic [15:0] p,
    input logic [31:0] exp_res, input logic exp_br);
    apply(op, f3, f7, ii, iu, i32, x, y, p);
    chk({tag, "_res"}, bus_if.ALU_result, exp_res);
    chk({tag, "_br"}, {31'b0, bus_if.branch}, {31'b0, exp_br});
  endtask

  logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                           7'b0010111, 7'b1111111, 7'b0000000};

  initial begin
    logic [31:0] lui_exp;
    logic [31:0] mres;
    logic        mbr;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [31:0] x, y;
    logic [11:0] ii;
    logic [19:0] iu;
    logic [31:0] i32;
    logic [15:0] p;
    logic [2:0]  f3;

    rst_n = 1'b0;
    bus_if.opcode = '0; bus_if.funct3 = '0; bus_if.funct7 = '0;
    bus_if.rs1 = '0; bus_if.rs2 = '0; bus_if.rd = '0;
    bus_if.imm_i = '0; bus_if.imm_s = '0; bus_if.imm_b = '0; bus_if.imm_j = '0;
    bus_if.imm_u = '0; bus_if.imm32 = '0; bus_if.read_data1 = '0;
    bus_if.read_data2 = '0; bus_if.pc = '0;
    #3;
    chk("rst_init_res", bus_if.ALU_result, 32'd0);
    chk("rst_init_br", {31'b0, bus_if.branch}, 32'd0);
    #9 rst_n = 1'b1;

    // R-type
    dir("add",  7'b0110011, 3'd0, 7'h00, 12'd0, 20'd0, 32'd0, 32'd10, 32'd5,  16'd0, 32'd15, 1'b0);
    dir("sub",  7'b0110011, 3'd0, 7'h20, 12'd0, 20'd0, 32'd0, 32'd10, 32'd5,  16'd0, 32'd5,  1'b0);
    dir("slt1", 7'b0110011, 3'd2, 7'h00, 12'd0, 20'd0, 32'd0, 32'd10, 32'd20, 16'd0, 32'd1,  1'b0);
    dir("slt0", 7'b0110011, 3'd2, 7'h00, 12'd0, 20'd0, 32'd0, 32'd30, 32'd20, 16'd0, 32'd0,  1'b0);
    dir("sll",  7'b0110011, 3'd1, 7'h00, 12'd0, 20'd0, 32'd2, 32'd10, 32'd0,  16'd0, 32'd40, 1'b0);
    // I-type
    dir("addi", 7'b0010011, 3'd0, 7'h00, 12'd20, 20'd0, 32'd0, 32'd10, 32'd0, 16'd0, 32'd30, 1'b0);
    dir("xori", 7'b0010011, 3'd4, 7'h00, 12'd2,  20'd0, 32'd0, 32'd10, 32'd0, 16'd0, 32'd8,  1'b0);
    dir("srli", 7'b0010011, 3'd5, 7'h00, 12'd0,  20'd0, 32'd2, 32'd10, 32'd0, 16'd0, 32'd2,  1'b0);
    dir("andi", 7'b0010011, 3'd7, 7'h00, 12'd20, 20'd0, 32'd0, 32'd10, 32'd0, 16'd0, 32'd0,  1'b0);
    dir("addin",7'b0010011, 3'd0, 7'h00, 12'hFFF,20'd0, 32'd0, 32'd10, 32'd0, 16'd0, 32'd9,  1'b0);
    dir("srai", 7'b0010011, 3'd5, 7'h20, 12'd0,  20'd0, 32'd4, 32'h80000000, 32'd0, 16'd0, 32'hF8000000, 1'b0);
    // Address
    dir("lw",   7'b0000011, 3'd2, 7'h00, 12'd0, 20'd0, 32'd12, 32'd100, 32'd7, 16'd0, 32'd112, 1'b0);
    dir("sw",   7'b0100011, 3'd2, 7'h00, 12'd0, 20'd0, 32'd12, 32'd100, 32'd7, 16'd0, 32'd112, 1'b0);
    // Branches
    dir("beq1", 7'b1100011, 3'd0, 7'h00, 12'd0, 20'd0, 32'd0, 32'd100, 32'd100, 16'd0, 32'd1, 1'b1);
    dir("beq0", 7'b1100011, 3'd0, 7'h00, 12'd0, 20'd0, 32'd0, 32'd100, 32'd10,  16'd0, 32'd0, 1'b0);
    dir("blt",  7'b1100011, 3'd4, 7'h00, 12'd0, 20'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 16'd0, 32'd1, 1'b1);
    dir("bltu", 7'b1100011, 3'd6, 7'h00, 12'd0, 20'd0, 32'd0, 32'hFFFFFFFF, 32'd1, 16'd0, 32'd0, 1'b0);
    dir("b010", 7'b1100011, 3'd2, 7'h00, 12'd0, 20'd0, 32'd0, 32'd5, 32'd5, 16'd0, 32'd0, 1'b0);
    // Jumps and U-type
    dir("jal",  7'b1101111, 3'd0, 7'h00, 12'd0, 20'd0, 32'd0, 32'd0, 32'd0, 16'd100, 32'd104, 1'b1);
`ifdef ALU_LUI_AUIPC_EN
    lui_exp = 32'h12345000;
`else
    lui_exp = 32'h0;
`endif
    dir("lui",  7'b0110111, 3'd0, 7'h00, 12'd0, 20'h12345, 32'd0, 32'd0, 32'd0, 16'd0, lui_exp, 1'b0);

    // Asynchronous reset with a nonzero pending result.
    dir("jalr", 7'b1100111, 3'd0, 7'h00, 12'd0, 20'd0, 32'd0, 32'd0, 32'd0, 16'd200, 32'd204, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_res", bus_if.ALU_result, 32'd0);
    chk("rst_async_br", {31'b0, bus_if.branch}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_res", bus_if.ALU_result, 32'd0);
    chk("rst_hold_br", {31'b0, bus_if.branch}, 32'd0);
    #2 rst_n = 1'b1;
    dir("post_rst", 7'b0110011, 3'd6, 7'h00, 12'd0, 20'd0, 32'd0, 32'h0F0, 32'h00F, 16'd0, 32'h0FF, 1'b0);

    // Randomized against the reference model.
    for (int n = 0; n < 500; n++) begin
      op  = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      f3  = 3'($urandom);
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      x   = $urandom;
      y   = ($urandom_range(0, 3) == 0) ? x : 32'($urandom);
      if ($urandom_range(0, 3) == 0) y = x ^ 32'h80000000;
      ii  = 12'($urandom);
      iu  = 20'($urandom);
      i32 = $urandom;
      p   = 16'($urandom);
      model(op, f3, f7, ii, iu, i32, x, y, p, mres, mbr);
      apply(op, f3, f7, ii, iu, i32, x, y, p);
      chk($sformatf("rnd%0d_op%h_f%0d_res", n, op, f3), bus_if.ALU_result, mres);
      chk($sformatf("rnd%0d_op%h_f%0d_br", n, op, f3), {31'b0, bus_if.branch}, {31'b0, mbr});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
